collision_event_hub: RTL and testbench
======================================

Name: collision_event_hub

Overview:
- Frame-level consumer of the pixel-rate collision pulses from the border/collision detector.
- Accumulates hit pulses as sticky flags during each video frame and publishes them once per frame at startOfFrame.
- Published outputs go to character, arrow and bubble movement logic as blocks and one-shot commands.
- Owns the game-event FSM: score, lives, post-hit freeze and game over.

Parameters:
- HIT_SCORE, 10, points added per frame in which arrowHitBubble occurred.
- SCORE_W, 16, score width in bits.
- LIVES_INIT, 3, lives after reset (1..7).
- FREEZE_FRAMES, 60, frames paused after a life is lost (1..255).

Ports:
- clk  in  1  system pixel clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse marking the frame boundary.
- charCrashLeft  in  1  pixel-rate pulse.
- charCrashRight  in  1  pixel-rate pulse.
- arrowHitTop  in  1  pixel-rate pulse.
- bubbleHitChar  in  1  pixel-rate pulse.
- arrowHitBubble  in  1  pixel-rate pulse.
- charBlockLeft  out  1  level, valid for the whole frame.
- charBlockRight  out  1  level, valid for the whole frame.
- arrowReset  out  1  one-cycle command: retract the arrow.
- bubbleSplit  out  1  one-cycle command: split the hit bubble.
- lifeLost  out  1  one-cycle pulse.
- score  out  SCORE_W  saturating score.
- lives  out  3  remaining lives.
- freeze  out  1  movement pause request.
- gameOver  out  1  sticky until reset.

Behaviour:
- Reset (sync, active-high, one cycle sufficient):
  - all sticky flags clear; FSM = PLAY; score = 0; lives = LIVES_INIT; freeze counter = 0.
  - all outputs 0 except lives.
  - Reset mid-frame discards any accumulated hits.
- Accumulation: each hit input sets its own sticky flag on any cycle it is high. Flags hold until the publish cycle.
- Publish, on the cycle startOfFrame = 1:
  - the current sticky values are used; every flag is then cleared.
  - A hit pulse on the same cycle as startOfFrame goes into the NEW frame's flags, not the published set.
- Latency: outputs update on the clock edge after the startOfFrame cycle, i.e. registered with a 1-cycle latency.
- Every publish:
  - charBlockLeft/Right take the sticky values and hold until the next publish.
  - They are published in all FSM states.
- FSM states: PLAY, FREEZE, GAME_OVER.
- PLAY, at publish:
  - If arrowHitBubble is set: bubbleSplit = 1 and arrowReset = 1 for one cycle; score += HIT_SCORE, saturating at 2^SCORE_W-1.
  - Else if arrowHitTop is set: arrowReset = 1 for one cycle.
  - If bubbleHitChar is set: lifeLost = 1 for one cycle and lives -= 1.
    - lives becomes 0 -> GAME_OVER.
    - otherwise -> FREEZE, counter = FREEZE_FRAMES.
  - Scoring and life loss in the same frame: both are applied; the score is updated first.
- FREEZE:
  - freeze = 1.
  - arrowHitTop, arrowHitBubble and bubbleHitChar are ignored: no commands, no score, no life loss.
  - Counter decrements at each publish. At the publish where the counter reaches 0 -> PLAY and freeze drops.
  - With FREEZE_FRAMES = 1 the hub spends exactly one full frame frozen.
- GAME_OVER:
  - freeze = 1 and gameOver = 1.
  - score and lives are frozen; all hits ignored except the char blocks.
  - Exit only by reset.
- Without startOfFrame, no output changes except by reset; flags keep accumulating.
- lives never underflows: a decrement happens only in PLAY with lives ≥ 1.

Decomposition:
- Shared game package holds:
  - the FSM state enum (PLAY, FREEZE, GAME_OVER);
  - the packed hit-flag struct {charLeft, charRight, arrowTop, bubbleChar, arrowBubble};
  - the x/y frame-size constants (639/479) already used by the collision detector.
- One natural sub-module, hit_accumulator: sticky flags with clear-on-startOfFrame, including the same-cycle rule.
- The FSM, score and lives live in the top level.

Test Plan:
- Reset, then a charCrashLeft pulse mid-frame, then startOfFrame -> next cycle charBlockLeft = 1 for the whole frame. With no hits in the following frame -> charBlockLeft = 0 after the next publish.
- Three arrowHitBubble pulses in one frame, HIT_SCORE = 10 -> one bubbleSplit pulse and one arrowReset pulse; score = 10, not 30.
- bubbleHitChar in PLAY with lives = 3, FREEZE_FRAMES = 2:
  - lifeLost pulse; lives = 2; freeze = 1 for exactly 2 publishes.
  - An arrowHitBubble during the freeze produces no bubbleSplit and no score change.
- Hit pulse asserted on the same cycle as startOfFrame -> absent from this publish; appears at the following publish.
- lives = 1 plus bubbleHitChar and arrowHitBubble in the same frame -> score += 10; lives = 0; gameOver = 1.
  - Further hits change nothing.
  - Reset restores lives = 3 and score = 0.
- Score saturation, SCORE_W = 4, HIT_SCORE = 10 -> score goes 10, then 15, then stays at 15.

Source files
------------

// File: rtl/collision_event_hub_pkg.sv
// Shared game definitions: FSM states, the hit-flag bundle and the frame geometry
// that the border/collision detector also uses.
package collision_event_hub_pkg;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    FREEZE    = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

  typedef struct packed {
    logic char_left;
    logic char_right;
    logic arrow_top;
    logic bubble_char;
    logic arrow_bubble;
  } hit_flags_t;

endpackage

// File: rtl/collision_event_hub_hit_accumulator.sv
// Sticky per-frame hit flags. The published set is the register content on the
// startOfFrame cycle; pulses arriving on that same cycle seed the next frame.
module hit_accumulator
  import collision_event_hub_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_of_frame,
  input  hit_flags_t hits,
  output hit_flags_t flags
);

  hit_flags_t flags_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= '0;
    end else if (start_of_frame) begin
      flags_reg <= hits;
    end else begin
      flags_reg <= flags_reg | hits;
    end
  end

  assign flags = flags_reg;

endmodule

// File: rtl/collision_event_hub.sv
// Frame-level collision event hub: publishes sticky hits once per frame and runs
// the score / lives / freeze / game-over state machine.
module collision_event_hub
  import collision_event_hub_pkg::*;
#(
  parameter int HIT_SCORE     = 10,
  parameter int SCORE_W       = 16,
  parameter int LIVES_INIT    = 3,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               charCrashLeft,
  input  logic               charCrashRight,
  input  logic               arrowHitTop,
  input  logic               bubbleHitChar,
  input  logic               arrowHitBubble,
  output logic               charBlockLeft,
  output logic               charBlockRight,
  output logic               arrowReset,
  output logic               bubbleSplit,
  output logic               lifeLost,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               freeze,
  output logic               gameOver
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W:0]   HIT_INC   = (SCORE_W+1)'(HIT_SCORE);

  hit_flags_t  hits;
  hit_flags_t  flags;
  game_state_t state_reg;
  game_state_t state_next;

  logic [SCORE_W-1:0] score_reg;
  logic [SCORE_W:0]   score_sum;
  logic [2:0]         lives_reg;
  logic [7:0]         freeze_cnt_reg;
  logic               publish_play;
  logic               add_score;
  logic               take_life;

  assign hits = '{char_left:    charCrashLeft,
                  char_right:   charCrashRight,
                  arrow_top:    arrowHitTop,
                  bubble_char:  bubbleHitChar,
                  arrow_bubble: arrowHitBubble};

  hit_accumulator u_hit_accumulator (
    .clk            (clk),
    .reset          (reset),
    .start_of_frame (startOfFrame),
    .hits           (hits),
    .flags          (flags)
  );

  assign publish_play = startOfFrame && (state_reg == PLAY);
  assign add_score    = publish_play && flags.arrow_bubble;
  assign take_life    = publish_play && flags.bubble_char && (lives_reg != 3'd0);
  // One extra bit catches the carry so the score pins at all-ones instead of wrapping.
  assign score_sum    = {1'b0, score_reg} + HIT_INC;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= PLAY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PLAY: begin
        if (take_life) begin
          state_next = (lives_reg == 3'd1) ? GAME_OVER : FREEZE;
        end
      end
      FREEZE: begin
        if (startOfFrame && (freeze_cnt_reg <= 8'd1)) begin
          state_next = PLAY;
        end
      end
      GAME_OVER: state_next = GAME_OVER;
      default:   state_next = PLAY;
    endcase
  end

  always_comb begin
    freeze   = (state_reg != PLAY);
    gameOver = (state_reg == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_reg      <= '0;
      lives_reg      <= 3'(LIVES_INIT);
      freeze_cnt_reg <= 8'd0;
      charBlockLeft  <= 1'b0;
      charBlockRight <= 1'b0;
      arrowReset     <= 1'b0;
      bubbleSplit    <= 1'b0;
      lifeLost       <= 1'b0;
    end else begin
      arrowReset  <= publish_play && (flags.arrow_bubble || flags.arrow_top);
      bubbleSplit <= add_score;
      lifeLost    <= take_life;
      if (startOfFrame) begin
        charBlockLeft  <= flags.char_left;
        charBlockRight <= flags.char_right;
      end
      if (add_score) begin
        score_reg <= score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
      end
      if (take_life) begin
        lives_reg      <= lives_reg - 3'd1;
        freeze_cnt_reg <= 8'(FREEZE_FRAMES);
      end else if (startOfFrame && (state_reg == FREEZE) && (freeze_cnt_reg != 8'd0)) begin
        freeze_cnt_reg <= freeze_cnt_reg - 8'd1;
      end
    end
  end

  assign score = score_reg;
  assign lives = lives_reg;

endmodule

// File: tb/tb_collision_event_hub.sv
// Directed bench for collision_event_hub: a main instance (16-bit score, 2 freeze
// frames) and a 4-bit score instance sharing the same stimulus for saturation.
module tb_collision_event_hub;

  logic clk = 1'b0;
  logic reset, startOfFrame;
  logic charCrashLeft, charCrashRight, arrowHitTop, bubbleHitChar, arrowHitBubble;

  logic        cbl_a, cbr_a, ar_a, bs_a, ll_a, frz_a, go_a;
  logic [15:0] score_a;
  logic [2:0]  lives_a;
  logic        cbl_b, cbr_b, ar_b, bs_b, ll_b, frz_b, go_b;
  logic [3:0]  score_b;
  logic [2:0]  lives_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_event_hub #(.HIT_SCORE(10), .SCORE_W(16), .LIVES_INIT(3), .FREEZE_FRAMES(2)) dut_a (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .charCrashLeft(charCrashLeft), .charCrashRight(charCrashRight), .arrowHitTop(arrowHitTop),
    .bubbleHitChar(bubbleHitChar), .arrowHitBubble(arrowHitBubble),
    .charBlockLeft(cbl_a), .charBlockRight(cbr_a), .arrowReset(ar_a), .bubbleSplit(bs_a),
    .lifeLost(ll_a), .score(score_a), .lives(lives_a), .freeze(frz_a), .gameOver(go_a)
  );

  collision_event_hub #(.HIT_SCORE(10), .SCORE_W(4), .LIVES_INIT(3), .FREEZE_FRAMES(2)) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .charCrashLeft(charCrashLeft), .charCrashRight(charCrashRight), .arrowHitTop(arrowHitTop),
    .bubbleHitChar(bubbleHitChar), .arrowHitBubble(arrowHitBubble),
    .charBlockLeft(cbl_b), .charBlockRight(cbr_b), .arrowReset(ar_b), .bubbleSplit(bs_b),
    .lifeLost(ll_b), .score(score_b), .lives(lives_b), .freeze(frz_b), .gameOver(go_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("[%0t] %s observed=%0d expected=%0d", $time, tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle pulse on the hit inputs: {left, right, top, bubbleChar, arrowBubble}.
  task automatic hit(input logic [4:0] v);
    {charCrashLeft, charCrashRight, arrowHitTop, bubbleHitChar, arrowHitBubble} = v;
    tick();
    {charCrashLeft, charCrashRight, arrowHitTop, bubbleHitChar, arrowHitBubble} = 5'b0;
    tick();
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0;
    {charCrashLeft, charCrashRight, arrowHitTop, bubbleHitChar, arrowHitBubble} = 5'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("reset_block_left", 32'(cbl_a), 0);
    chk("reset_arrow_reset", 32'(ar_a), 0);
    chk("reset_split", 32'(bs_a), 0);
    chk("reset_life_lost", 32'(ll_a), 0);
    chk("reset_score", 32'(score_a), 0);
    chk("reset_lives", 32'(lives_a), 3);
    chk("reset_freeze", 32'(frz_a), 0);
    chk("reset_game_over", 32'(go_a), 0);

    // Char block published for a whole frame, then cleared by an empty frame.
    hit(5'b10000);
    chk("block_left_before_publish", 32'(cbl_a), 0);
    sof();
    chk("block_left_published", 32'(cbl_a), 1);
    chk("block_right_quiet", 32'(cbr_a), 0);
    repeat (5) tick();
    chk("block_left_held", 32'(cbl_a), 1);
    sof();
    chk("block_left_cleared", 32'(cbl_a), 0);

    // Three bubble hits in one frame score once.
    hit(5'b00001); hit(5'b00001); hit(5'b00001);
    sof();
    chk("multi_hit_split", 32'(bs_a), 1);
    chk("multi_hit_arrow_reset", 32'(ar_a), 1);
    chk("multi_hit_score", 32'(score_a), 10);
    chk("multi_hit_score_w4", 32'(score_b), 10);
    tick();
    chk("split_one_shot", 32'(bs_a), 0);
    chk("arrow_reset_one_shot", 32'(ar_a), 0);

    // Hit coincident with startOfFrame belongs to the next frame.
    arrowHitTop = 1'b1; startOfFrame = 1'b1;
    tick();
    arrowHitTop = 1'b0; startOfFrame = 1'b0;
    chk("same_cycle_not_published", 32'(ar_a), 0);
    tick();
    sof();
    chk("same_cycle_next_publish", 32'(ar_a), 1);
    chk("arrow_top_no_split", 32'(bs_a), 0);
    chk("arrow_top_no_score", 32'(score_a), 10);

    // Saturation on the 4-bit instance: 10 -> 15 -> 15.
    hit(5'b00001);
    sof();
    chk("score_a_20", 32'(score_a), 20);
    chk("score_b_sat_15", 32'(score_b), 15);
    hit(5'b00001);
    sof();
    chk("score_a_30", 32'(score_a), 30);
    chk("score_b_stays_15", 32'(score_b), 15);

    // Life lost, two frozen publishes, hits ignored while frozen.
    hit(5'b00010);
    sof();
    chk("life_lost_pulse", 32'(ll_a), 1);
    chk("lives_2", 32'(lives_a), 2);
    chk("freeze_entered", 32'(frz_a), 1);
    tick();
    chk("life_lost_one_shot", 32'(ll_a), 0);
    hit(5'b00011);
    sof();
    chk("freeze_still_on", 32'(frz_a), 1);
    chk("freeze_no_split", 32'(bs_a), 0);
    chk("freeze_no_life_lost", 32'(ll_a), 0);
    chk("freeze_score_kept", 32'(score_a), 30);
    chk("freeze_lives_kept", 32'(lives_a), 2);
    sof();
    chk("freeze_released", 32'(frz_a), 0);

    // Down to one life, then a frame with both a score and the final hit.
    hit(5'b00010);
    sof();
    chk("lives_1", 32'(lives_a), 1);
    sof(); sof();
    chk("freeze_released_again", 32'(frz_a), 0);
    hit(5'b00011);
    sof();
    chk("final_score", 32'(score_a), 40);
    chk("final_lives", 32'(lives_a), 0);
    chk("game_over_set", 32'(go_a), 1);
    chk("game_over_freeze", 32'(frz_a), 1);
    chk("final_split", 32'(bs_a), 1);
    chk("final_life_lost", 32'(ll_a), 1);

    // Game over ignores everything except the char blocks.
    hit(5'b11111);
    sof();
    chk("go_score_frozen", 32'(score_a), 40);
    chk("go_lives_frozen", 32'(lives_a), 0);
    chk("go_no_arrow_reset", 32'(ar_a), 0);
    chk("go_no_split", 32'(bs_a), 0);
    chk("go_no_life_lost", 32'(ll_a), 0);
    chk("go_block_left", 32'(cbl_a), 1);
    chk("go_sticky", 32'(go_a), 1);

    // Reset mid-frame discards accumulated hits and restores the game.
    hit(5'b01000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_lives", 32'(lives_a), 3);
    chk("rst2_score", 32'(score_a), 0);
    chk("rst2_game_over", 32'(go_a), 0);
    chk("rst2_block_left", 32'(cbl_a), 0);
    sof();
    chk("rst2_hits_discarded", 32'(cbr_a), 0);
    chk("rst2_score_w4", 32'(score_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
